conv_window_ctrl: RTL and testbench
===================================

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter KSIZE, default 3, kernel edge length (2..7).
REQ-002 SHALL have parameter MAX_DIM, default 32, maximum row length and column count.
REQ-003 SHALL have parameter DIM_W, default 6, width of dimension and coordinate fields (holds MAX_DIM).
REQ-004 SHALL have parameter STRIDE_W, default 3, width of the stride field.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cfg_load  in  1  one-cycle pulse that latches the cfg_* fields.
REQ-008 cfg_row_len  in  DIM_W  pixels per row.
REQ-009 cfg_col_len  in  DIM_W  rows per frame.
REQ-010 cfg_stride  in  STRIDE_W  window step, in pixels, for both axes.
REQ-011 in_valid  in  1  an input pixel is presented.
REQ-012 in_ready  out  1  the controller accepts the pixel (accept = in_valid & in_ready).
REQ-013 lb_wen  out  1  line-buffer write enable; equals accept.
REQ-014 lb_ren  out  1  line-buffer read enable; equals accept & (row_cnt != 0).
REQ-015 win_valid  out  1  a complete KSIZE x KSIZE window is ready.
REQ-016 win_ready  in  1  the downstream consumer takes the window.
REQ-017 win_x, win_y  out  DIM_W each  output-map coordinate of the current window.
REQ-018 frame_done  out  1  one-cycle pulse at the end of a frame.
REQ-019 cfg_err  out  1  one-cycle pulse when a configuration is rejected.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, FLUSH and DONE.
REQ-021 In IDLE, a cfg_load with stride>=1, row_len>=KSIZE, col_len>=KSIZE, row_len<=MAX_DIM and col_len<=MAX_DIM SHALL:
- latch the three cfg_* fields;
- clear col_cnt, row_cnt, win_x, win_y and the stride phases;
- enter RUN.
REQ-022 In IDLE, any other cfg_load SHALL pulse cfg_err for one cycle, and the FSM SHALL stay in IDLE.
REQ-023 cfg_load outside IDLE SHALL be ignored.
REQ-024 in_ready SHALL be 1 only in RUN, and only while !(win_valid & !win_ready).
REQ-025 Each accept SHALL advance col_cnt.
REQ-026 col_cnt SHALL wrap from row_len-1 to 0 and increment row_cnt.
REQ-027 An accepted pixel at (col_cnt, row_cnt) SHALL produce a window when all of the following hold:
- col_cnt >= KSIZE-1;
- row_cnt >= KSIZE-1;
- the column phase (col_cnt-(KSIZE-1)) mod stride == 0;
- the row phase (row_cnt-(KSIZE-1)) mod stride == 0.
The two phases SHALL be tracked with phase counters, not dividers.
REQ-028 win_valid SHALL rise the cycle after a producing accept and hold until sampled with win_ready=1.
REQ-029 win_x and win_y SHALL be stable while win_valid=1.
REQ-030 win_x SHALL increment per produced window within a row and clear at each row wrap.
REQ-031 win_y SHALL increment after a row that produced at least one window.
REQ-032 A handshake and a new producing accept in the same cycle SHALL keep win_valid=1 and present the new coordinates; no window SHALL be lost.
REQ-033 Accepting pixel (row_len-1, col_len-1) SHALL move the FSM to FLUSH.
REQ-034 FLUSH SHALL wait until win_valid=0 or a handshake occurs, then enter DONE.
REQ-035 DONE SHALL pulse frame_done for one cycle and return to IDLE.
REQ-036 Counter arithmetic SHALL be unsigned DIM_W.
REQ-037 Stride larger than row_len-KSIZE+1 SHALL yield exactly one window column (x=0).

Reset
REQ-038 rst SHALL force, on the next edge:
- state=IDLE;
- in_ready, win_valid, lb_wen, lb_ren, frame_done and cfg_err to 0;
- all counters, phases, win_x and win_y to 0;
- the latched cfg fields to 0.
REQ-039 rst SHALL take priority over cfg_load, accept and handshake, including in the middle of a frame.

Configuration
REQ-040 Macro CONV_WIN_STATS_EN: when defined, the block SHALL add output win_count (16 bits), counting handshaken windows; it clears on a valid cfg_load and on rst and saturates at 0xFFFF.
REQ-041 When CONV_WIN_STATS_EN is undefined, win_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-042 KSIZE=3, 5x5, stride 1, win_ready=1 -> 9 windows; the first win_valid follows the 13th accept with (x,y)=(0,0); the last is (2,2); frame_done pulses once.
REQ-043 KSIZE=3, 5x5, stride 2 -> 4 windows at (0,0),(1,0),(0,1),(1,1), produced by the pixels at col/row (2,2),(4,2),(2,4),(4,4).
REQ-044 Stride 1, win_ready held 0 for 5 cycles at the first window -> in_ready=0 for those cycles, no accepts, no lost window, 9 windows total.
REQ-045 cfg_load with stride=0, or with row_len=2 -> cfg_err pulses once, the FSM stays IDLE, in_ready=0.
REQ-046 rst asserted after 10 accepts -> all outputs 0 next cycle; a new 5x5 frame then produces 9 windows correctly.
REQ-047 With CONV_WIN_STATS_EN defined, after the REQ-042 frame -> win_count=9; a new valid cfg_load clears it to 0.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// Sliding-window controller for a KSIZE x KSIZE convolution over a streamed frame.
// Optional window counter output enabled by defining CONV_WIN_STATS_EN.
module conv_window_ctrl #(
    parameter int KSIZE    = 3,
    parameter int MAX_DIM  = 32,
    parameter int DIM_W    = 6,
    parameter int STRIDE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_load,
    input  logic [DIM_W-1:0]    cfg_row_len,
    input  logic [DIM_W-1:0]    cfg_col_len,
    input  logic [STRIDE_W-1:0] cfg_stride,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                lb_wen,
    output logic                lb_ren,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [DIM_W-1:0]    win_x,
    output logic [DIM_W-1:0]    win_y,
    output logic                frame_done,
    output logic                cfg_err
`ifdef CONV_WIN_STATS_EN
    ,output logic [15:0]        win_count
`endif
);

    localparam logic [DIM_W-1:0] K1 = DIM_W'(KSIZE - 1);
    localparam logic [DIM_W-1:0] KD = DIM_W'(KSIZE);
    localparam logic [DIM_W-1:0] MD = DIM_W'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    row_len_q, row_len_d, col_len_q, col_len_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [DIM_W-1:0]    col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
    logic [STRIDE_W-1:0] cph_q, cph_d, rph_q, rph_d;
    logic [DIM_W-1:0]    nx_q, nx_d, ny_q, ny_d;
    logic [DIM_W-1:0]    win_x_q, win_x_d, win_y_q, win_y_d;
    logic                row_had_q, row_had_d;
    logic                win_valid_q, win_valid_d;
    logic                cfg_err_q, cfg_err_d;

    logic cfg_ok, accept, hs, col_in, row_in, col_last, row_last, produce;

    assign in_ready   = (state_q == RUN) && !(win_valid_q && !win_ready);
    assign accept     = in_valid && in_ready;
    assign hs         = win_valid_q && win_ready;
    assign lb_wen     = accept;
    assign lb_ren     = accept && (row_cnt_q != '0);
    assign win_valid  = win_valid_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = (state_q == DONE);
    assign cfg_err    = cfg_err_q;

    assign cfg_ok = (cfg_stride != '0) && (cfg_row_len >= KD) && (cfg_col_len >= KD) &&
                    (cfg_row_len <= MD) && (cfg_col_len <= MD);
    assign col_in   = col_cnt_q >= K1;
    assign row_in   = row_cnt_q >= K1;
    assign col_last = col_cnt_q == row_len_q - 1'b1;
    assign row_last = row_cnt_q == col_len_q - 1'b1;
    // Phases are only meaningful once the window fits; zero phase marks a stride hit.
    assign produce  = accept && col_in && row_in && (cph_q == '0) && (rph_q == '0);

    always_comb begin
        state_d     = state_q;
        row_len_d   = row_len_q;
        col_len_d   = col_len_q;
        stride_d    = stride_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        cph_d       = cph_q;
        rph_d       = rph_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        row_had_d   = row_had_q;
        win_valid_d = win_valid_q;
        cfg_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    if (cfg_ok) begin
                        row_len_d = cfg_row_len;
                        col_len_d = cfg_col_len;
                        stride_d  = cfg_stride;
                        col_cnt_d = '0;
                        row_cnt_d = '0;
                        cph_d     = '0;
                        rph_d     = '0;
                        nx_d      = '0;
                        ny_d      = '0;
                        win_x_d   = '0;
                        win_y_d   = '0;
                        row_had_d = 1'b0;
                        state_d   = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept && col_last && row_last) state_d = FLUSH;
            end
            FLUSH: begin
                if (!win_valid_q || hs) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (col_in) cph_d = (cph_q + 1'b1 == stride_q) ? '0 : cph_q + 1'b1;
            if (produce) begin
                win_x_d   = nx_q;
                win_y_d   = ny_q;
                nx_d      = nx_q + 1'b1;
                row_had_d = 1'b1;
            end
            if (col_last) begin
                col_cnt_d = '0;
                row_cnt_d = row_cnt_q + 1'b1;
                cph_d     = '0;
                nx_d      = '0;
                row_had_d = 1'b0;
                if (row_had_q || produce) ny_d = ny_q + 1'b1;
                if (row_in) rph_d = (rph_q + 1'b1 == stride_q) ? '0 : rph_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end

        // Accept is blocked while a window is stalled, so a new window never overwrites one.
        if (produce)  win_valid_d = 1'b1;
        else if (hs)  win_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_len_q   <= '0;
            col_len_q   <= '0;
            stride_q    <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            cph_q       <= '0;
            rph_q       <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            row_had_q   <= 1'b0;
            win_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_len_q   <= row_len_d;
            col_len_q   <= col_len_d;
            stride_q    <= stride_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            cph_q       <= cph_d;
            rph_q       <= rph_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            row_had_q   <= row_had_d;
            win_valid_q <= win_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef CONV_WIN_STATS_EN
    logic [15:0] win_count_q;

    always_ff @(posedge clk) begin
        if (rst)                                          win_count_q <= '0;
        else if (state_q == IDLE && cfg_load && cfg_ok)  win_count_q <= '0;
        else if (hs && win_count_q != 16'hFFFF)          win_count_q <= win_count_q + 16'd1;
    end

    assign win_count = win_count_q;
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: frames with stride 1/2/5, stall, bad config, mid-frame reset.
module tb_conv_window_ctrl;
    localparam int DIM_W = 6;
    localparam int STRIDE_W = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_load = 1'b0;
    logic [DIM_W-1:0]    cfg_row_len = '0;
    logic [DIM_W-1:0]    cfg_col_len = '0;
    logic [STRIDE_W-1:0] cfg_stride = '0;
    logic                in_valid = 1'b0;
    logic                in_ready, lb_wen, lb_ren, win_valid, frame_done, cfg_err;
    logic                win_ready = 1'b1;
    logic [DIM_W-1:0]    win_x, win_y;
`ifdef CONV_WIN_STATS_EN
    logic [15:0]         win_count;
`endif

    conv_window_ctrl #(.KSIZE(3), .MAX_DIM(32), .DIM_W(DIM_W), .STRIDE_W(STRIDE_W)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_row_len(cfg_row_len),
        .cfg_col_len(cfg_col_len), .cfg_stride(cfg_stride), .in_valid(in_valid),
        .in_ready(in_ready), .lb_wen(lb_wen), .lb_ren(lb_ren), .win_valid(win_valid),
        .win_ready(win_ready), .win_x(win_x), .win_y(win_y), .frame_done(frame_done),
        .cfg_err(cfg_err)
`ifdef CONV_WIN_STATS_EN
        ,.win_count(win_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Monitor samples at negedge: what it sees is what the next posedge will take.
    logic mon_clr = 1'b0;
    int   acc, ren_cnt, fd_cnt, err_cnt, rdy_bad, first_acc;
    logic seen_first;
    int   wx[$];
    int   wy[$];

    always @(negedge clk) begin
        if (mon_clr) begin
            acc <= 0; ren_cnt <= 0; fd_cnt <= 0; err_cnt <= 0; rdy_bad <= 0;
            first_acc <= -1; seen_first <= 1'b0;
            wx.delete(); wy.delete();
        end else begin
            if (win_valid && !seen_first) begin
                seen_first <= 1'b1;
                first_acc  <= acc;
            end
            if (win_valid && win_ready) begin
                wx.push_back(int'(win_x));
                wy.push_back(int'(win_y));
            end
            if (in_valid && in_ready) acc <= acc + 1;
            if (lb_ren) ren_cnt <= ren_cnt + 1;
            if (frame_done) fd_cnt <= fd_cnt + 1;
            if (cfg_err) err_cnt <= err_cnt + 1;
            if (!win_ready && in_ready) rdy_bad <= rdy_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic load_cfg(input int rl, input int cl, input int st);
        cfg_row_len = DIM_W'(rl);
        cfg_col_len = DIM_W'(cl);
        cfg_stride  = STRIDE_W'(st);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic run_frame(input int rl, input int cl, input int st, input int stall);
        int stall_left;
        clr_mon();
        load_cfg(rl, cl, st);
        in_valid = 1'b1;
        stall_left = stall;
        for (int c = 0; c < 2000 && fd_cnt == 0; c++) begin
            tick();
            if (stall_left > 0 && win_valid) begin
                win_ready = 1'b0;
                stall_left--;
            end else begin
                win_ready = 1'b1;
            end
        end
        win_ready = 1'b1;
        chk("frame_done_seen", 32'(fd_cnt > 0), 1);
        in_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready), 0);
        chk({tag, "_win_valid"},  32'(win_valid), 0);
        chk({tag, "_lb_wen"},     32'(lb_wen), 0);
        chk({tag, "_lb_ren"},     32'(lb_ren), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_cfg_err"},    32'(cfg_err), 0);
        chk({tag, "_win_x"},      32'(win_x), 0);
        chk({tag, "_win_y"},      32'(win_y), 0);
    endtask

    task automatic chk_s1_list(input string tag);
        chk({tag, "_nwin"}, 32'(wx.size()), 9);
        for (int i = 0; i < 9 && i < wx.size(); i++) begin
            chk({tag, "_x"}, 32'(wx[i]), 32'(i % 3));
            chk({tag, "_y"}, 32'(wy[i]), 32'(i / 3));
        end
    endtask

    initial begin
        // reset with inputs active: everything must read 0
        in_valid = 1'b1;
        cfg_load = 1'b1;
        cfg_row_len = 6'd5; cfg_col_len = 6'd5; cfg_stride = 3'd1;
        repeat (2) tick();
        chk_idle_outputs("reset");
        cfg_load = 1'b0;
        in_valid = 1'b0;
        rst = 1'b0;
        tick();

        // 5x5 stride 1, free-running consumer
        run_frame(5, 5, 1, 0);
        chk_s1_list("s1");
        chk("s1_first_acc", 32'(first_acc), 13);
        chk("s1_accepts", 32'(acc), 25);
        chk("s1_lb_ren", 32'(ren_cnt), 20);
        chk("s1_frame_done_once", 32'(fd_cnt), 1);
`ifdef CONV_WIN_STATS_EN
        chk("stats_count", 32'(win_count), 9);
`endif

        // stride 2: pixels (2,2),(4,2),(2,4),(4,4)
        run_frame(5, 5, 2, 0);
        chk("s2_nwin", 32'(wx.size()), 4);
        chk("s2_first_acc", 32'(first_acc), 13);
        for (int i = 0; i < 4 && i < wx.size(); i++) begin
            chk("s2_x", 32'(wx[i]), 32'(i % 2));
            chk("s2_y", 32'(wy[i]), 32'(i / 2));
        end

        // stride beyond the span: single window at (0,0)
        run_frame(5, 5, 5, 0);
        chk("s5_nwin", 32'(wx.size()), 1);
        if (wx.size() > 0) begin
            chk("s5_x", 32'(wx[0]), 0);
            chk("s5_y", 32'(wy[0]), 0);
        end

        // consumer stalls 5 cycles at the first window
        run_frame(5, 5, 1, 5);
        chk_s1_list("stall");
        chk("stall_ready_hi", 32'(rdy_bad), 0);
        chk("stall_accepts", 32'(acc), 25);

        // rejected configurations
        clr_mon();
        in_valid = 1'b1;
        load_cfg(5, 5, 0);
        tick();
        load_cfg(2, 5, 1);
        tick();
        load_cfg(33, 5, 1);
        repeat (2) tick();
        chk("cfgerr_count", 32'(err_cnt), 3);
        chk("cfgerr_in_ready", 32'(in_ready), 0);
        chk("cfgerr_accepts", 32'(acc), 0);
        in_valid = 1'b0;
        tick();

        // reset after 10 accepts, then a clean frame
        clr_mon();
        load_cfg(5, 5, 1);
        in_valid = 1'b1;
        for (int c = 0; c < 100 && acc < 10; c++) tick();
        chk("midrst_acc10", 32'(acc), 10);
        rst = 1'b1;
        tick();
        chk_idle_outputs("midrst");
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        run_frame(5, 5, 1, 0);
        chk_s1_list("post_rst");

        // a cfg_load while running must not disturb the frame
        clr_mon();
        load_cfg(5, 5, 1);
        in_valid = 1'b1;
        repeat (4) tick();
        load_cfg(9, 9, 2);
        for (int c = 0; c < 2000 && fd_cnt == 0; c++) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("busy_cfg_nwin", 32'(wx.size()), 9);
        chk("busy_cfg_accepts", 32'(acc), 25);

`ifdef CONV_WIN_STATS_EN
        chk("stats_before_clear", 32'(win_count), 9);
        load_cfg(5, 5, 1);
        chk("stats_cleared", 32'(win_count), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
